// File: rtl/audio_sample_buffer_pkg.sv
// Shared types for the audio sample buffer: sample width and byte-pairing states.
package audio_sample_buffer_pkg;

   localparam int AUDIO_W = 16;

   typedef logic [AUDIO_W-1:0] sample_t;

   typedef enum logic {
      LO = 1'b0,
      HI = 1'b1
   } pair_state_t;

endpackage

// File: rtl/audio_sample_buffer_if.sv
// Byte-stream, read-enable and status signals between the storage reader/serializer and the buffer.
interface audio_sample_buffer_if #(
   parameter int DEPTH = 32
);
   import audio_sample_buffer_pkg::*;

   logic [7:0]             i_byte;
   logic                   i_byte_valid;
   logic                   o_byte_ready;
   logic                   i_renb;
   logic                   i_flush;
   sample_t                o_audio_data;
   logic [$clog2(DEPTH):0] o_level;
   logic                   o_refill;
   logic [15:0]            o_underrun_cnt;

   modport master (
      output i_byte, i_byte_valid, i_renb, i_flush,
      input  o_byte_ready, o_audio_data, o_level, o_refill, o_underrun_cnt
   );

   modport slave (
      input  i_byte, i_byte_valid, i_renb, i_flush,
      output o_byte_ready, o_audio_data, o_level, o_refill, o_underrun_cnt
   );

endinterface

// File: rtl/audio_sample_buffer_sample_fifo.sv
// Single-clock sample FIFO with registered read data and an explicit level counter.
module sample_fifo
   import audio_sample_buffer_pkg::*;
#(
   parameter int DEPTH = 32
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_clr,
   input  logic                   i_wr,
   input  sample_t                i_wdata,
   input  logic                   i_rd,
   output sample_t                o_rdata,
   output logic [$clog2(DEPTH):0] o_level,
   output logic                   o_full,
   output logic                   o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   sample_t       mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_wr;
   logic          do_rd;

   assign o_full  = (o_level == LW'(DEPTH));
   assign o_empty = (o_level == '0);
   assign do_wr   = i_wr && !o_full;
   assign do_rd   = i_rd && !o_empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         o_level <= '0;
         o_rdata <= '0;
      end else if (i_clr) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         o_level <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) begin
            rd_ptr  <= rd_ptr + 1'b1;
            o_rdata <= mem[rd_ptr];
         end
         if (do_wr && !do_rd)      o_level <= o_level + 1'b1;
         else if (do_rd && !do_wr) o_level <= o_level - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_wr && !i_clr) mem[wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/audio_sample_buffer.sv
// Pairs little-endian PCM bytes into 16-bit samples and serves one per read-enable edge.
//  state | meaning
//  LO    | waiting for the low byte of the next sample
//  HI    | low byte latched, next accepted byte completes the sample
module audio_sample_buffer
   import audio_sample_buffer_pkg::*;
#(
   parameter int DEPTH = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   audio_sample_buffer_if.slave bus
);
   localparam int             LW   = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0]  HALF = LW'(DEPTH / 2);

   pair_state_t   state;
   logic [7:0]    lo_byte;
   logic          wr_q;
   sample_t       wdata_q;
   logic          renb_q;
   logic          rd_req;
   logic          pop_q;
   logic          und_q;
   logic          accept;
   sample_t       fifo_rdata;
   sample_t       audio_q;
   logic [15:0]   ucnt_q;
   logic [LW-1:0] level;
   logic          full;
   logic          empty;

   assign rd_req = bus.i_renb ^ renb_q;
   assign accept = bus.i_byte_valid && !full;

   assign bus.o_byte_ready   = !full;
   assign bus.o_level        = level;
   assign bus.o_refill       = (level <= HALF);
   assign bus.o_audio_data   = audio_q;
   assign bus.o_underrun_cnt = ucnt_q;

   sample_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (bus.i_flush),
      .i_wr    (wr_q),
      .i_wdata (wdata_q),
      .i_rd    (rd_req),
      .o_rdata (fifo_rdata),
      .o_level (level),
      .o_full  (full),
      .o_empty (empty)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= LO;
         lo_byte <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         wr_q <= 1'b0;
         if (bus.i_flush) begin
            state <= LO;
         end else if (accept) begin
            if (state == LO) begin
               lo_byte <= bus.i_byte;
               state   <= HI;
            end else begin
               wdata_q <= {bus.i_byte, lo_byte};
               wr_q    <= 1'b1;
               state   <= LO;
            end
         end
      end
   end

   // Popped data arrives from the FIFO one cycle after the request; the output follows it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         renb_q  <= 1'b0;
         pop_q   <= 1'b0;
         und_q   <= 1'b0;
         audio_q <= '0;
         ucnt_q  <= '0;
      end else begin
         renb_q <= bus.i_renb;
         if (bus.i_flush) begin
            pop_q   <= 1'b0;
            und_q   <= 1'b0;
            audio_q <= '0;
         end else begin
            pop_q <= rd_req && !empty;
            und_q <= rd_req && empty;
            if (pop_q)      audio_q <= fifo_rdata;
            else if (und_q) audio_q <= '0;
            if (rd_req && empty && (ucnt_q != 16'hFFFF)) ucnt_q <= ucnt_q + 16'd1;
         end
      end
   end

endmodule
